// File: rtl/seq_alu_if.sv
// Bundles the request/response signals of the sequential MIPS-style ALU.
// Latency: none (wires only).
// Backpressure: requester watches busy/done; starts while busy are dropped by the ALU.
interface seq_alu_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic [WIDTH-1:0]   read_data_1;
  logic [WIDTH-1:0]   read_data_2;
  logic [SHAMT_W-1:0] shamt;
  logic [3:0]         ALU_control;
  logic [WIDTH-1:0]   ALU_result;
  logic               zero;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  // Requester side (control unit / pipeline EX stage)
  modport master (
    output start, read_data_1, read_data_2, shamt, ALU_control,
    input  ALU_result, zero, busy, done, hi, lo
  );

  // ALU side
  modport slave (
    input  start, read_data_1, read_data_2, shamt, ALU_control,
    output ALU_result, zero, busy, done, hi, lo
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle MIPS ALU: single-cycle logic/arith/shift ops plus iterative multu/divu into HI/LO.
// Latency: 1 cycle for single-cycle ops and divu by zero; WIDTH+1 cycles for multu/divu.
// Backpressure: busy=1 while iterating; start is ignored (not queued) until busy drops.
// Optional divider datapath and DIV state are built only when SEQ_ALU_DIV_EN is defined.
module seq_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input logic    clk,
  input logic    reset,
  seq_alu_if.slave alu
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam logic [3:0] OP_MFHI  = 4'b1010;
  localparam logic [3:0] OP_MFLO  = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_SLL   = 4'b1101;
  localparam logic [3:0] OP_SRL   = 4'b1110;
  localparam logic [3:0] OP_SRA   = 4'b1111;

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1
`ifdef SEQ_ALU_DIV_EN
    ,
    S_DIV  = 2'd2
`endif
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   result_q, hi_q, lo_q, opnd_q;
  logic               zero_q, done_q, busy;
  // Shared iteration register: {partial product, multiplier} or {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               last_step;
  logic [31:0]        sh;
  logic [WIDTH-1:0]   sc_res;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt;
`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] div_nxt;
`endif

  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
  assign sh        = 32'(alu.shamt) % 32'(WIDTH);

  // Single-cycle result from the live operands and the current HI/LO
  always_comb begin
    sc_res = '0;
    case (alu.ALU_control)
      OP_AND:  sc_res = alu.read_data_1 & alu.read_data_2;
      OP_OR:   sc_res = alu.read_data_1 | alu.read_data_2;
      OP_ADD:  sc_res = alu.read_data_1 + alu.read_data_2;
      OP_SUB:  sc_res = alu.read_data_1 - alu.read_data_2;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(alu.read_data_1) < $signed(alu.read_data_2))};
      OP_NOR:  sc_res = ~(alu.read_data_1 | alu.read_data_2);
      OP_SLL:  sc_res = alu.read_data_2 << sh;
      OP_SRL:  sc_res = alu.read_data_2 >> sh;
      OP_SRA:  sc_res = $signed(alu.read_data_2) >>> sh;
      OP_MFHI: sc_res = hi_q;
      OP_MFLO: sc_res = lo_q;
      default: sc_res = '0;
    endcase
  end

  // One shift-add step: add multiplicand when the multiplier LSB is set, then shift right
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
    mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};
  end

`ifdef SEQ_ALU_DIV_EN
  // One restoring-divide step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (!div_diff[WIDTH])
      div_nxt = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else
      div_nxt = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: enter an iterative state on an accepted multu/divu, leave after WIDTH steps
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (alu.start) begin
          if (alu.ALU_control == OP_MULTU)
            state_nxt = S_MUL;
`ifdef SEQ_ALU_DIV_EN
          else if (alu.ALU_control == OP_DIVU && alu.read_data_2 != '0)
            state_nxt = S_DIV;
`endif
        end
      end
      S_MUL:   if (last_step) state_nxt = S_IDLE;
`ifdef SEQ_ALU_DIV_EN
      S_DIV:   if (last_step) state_nxt = S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state != S_IDLE);
  end

  // Datapath: operand capture, iteration, and result/HI/LO/done registers
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (alu.start) begin
            if (alu.ALU_control == OP_MULTU) begin
              acc_q  <= {{WIDTH{1'b0}}, alu.read_data_2};
              opnd_q <= alu.read_data_1;
              cnt_q  <= '0;
            end
`ifdef SEQ_ALU_DIV_EN
            else if (alu.ALU_control == OP_DIVU) begin
              if (alu.read_data_2 != '0) begin
                acc_q  <= {{WIDTH{1'b0}}, alu.read_data_1};
                opnd_q <= alu.read_data_2;
                cnt_q  <= '0;
              end else begin
                // Divide by zero: quotient saturates, remainder is the dividend
                lo_q     <= '1;
                hi_q     <= alu.read_data_1;
                result_q <= '1;
                zero_q   <= 1'b0;
                done_q   <= 1'b1;
              end
            end
`endif
            else begin
              result_q <= sc_res;
              zero_q   <= (sc_res == '0);
              done_q   <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc_q <= mul_nxt;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_step) begin
            hi_q     <= mul_nxt[2*WIDTH-1:WIDTH];
            lo_q     <= mul_nxt[WIDTH-1:0];
            result_q <= mul_nxt[WIDTH-1:0];
            zero_q   <= (mul_nxt[WIDTH-1:0] == '0);
            done_q   <= 1'b1;
          end
        end
`ifdef SEQ_ALU_DIV_EN
        S_DIV: begin
          acc_q <= div_nxt;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_step) begin
            hi_q     <= div_nxt[2*WIDTH-1:WIDTH];
            lo_q     <= div_nxt[WIDTH-1:0];
            result_q <= div_nxt[WIDTH-1:0];
            zero_q   <= (div_nxt[WIDTH-1:0] == '0);
            done_q   <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign alu.ALU_result = result_q;
  assign alu.zero       = zero_q;
  assign alu.busy       = busy;
  assign alu.done       = done_q;
  assign alu.hi         = hi_q;
  assign alu.lo         = lo_q;

endmodule

// File: tb/tb_seq_alu.sv
// Randomized plus directed bench for seq_alu (WIDTH=32) with an arithmetic reference model.
// Latency: expected done latency is recorded per request and compared by the monitor.
// Backpressure: the driver waits for busy=0 before each tracked request.
module tb_seq_alu;
  localparam int W = 32;

  localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001, ADD = 4'b0010, SUB = 4'b0110;
  localparam logic [3:0] SLT = 4'b0111, MULTU = 4'b1000, DIVU = 4'b1001, MFHI = 4'b1010;
  localparam logic [3:0] MFLO = 4'b1011, NOR_ = 4'b1100, SLL = 4'b1101, SRL = 4'b1110;
  localparam logic [3:0] SRA = 4'b1111;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] res;
    logic         z;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           issue_cyc;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  seq_alu_if #(.WIDTH(W), .SHAMT_W(5)) bus ();

  seq_alu #(.WIDTH(W), .SHAMT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .alu   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pops one expected response
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0) begin
      chk("busy_and_done", {31'b0, (bus.busy & bus.done)}, '0);
      if (bus.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("result op%b", e.op), bus.ALU_result, e.res);
          chk($sformatf("zero op%b", e.op), {31'b0, bus.zero}, {31'b0, e.z});
          chk($sformatf("hi op%b", e.op), bus.hi, e.hi);
          chk($sformatf("lo op%b", e.op), bus.lo, e.lo);
          chk($sformatf("latency op%b", e.op), W'(cyc - e.issue_cyc), W'(e.lat));
        end
      end
    end
  end

  // Reference model: plain arithmetic on operands and the model's own HI/LO
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] sh);
    exp_t e;
    logic [2*W-1:0] p;
    logic [W-1:0] r;
    int s;
    s = int'(sh) % W;
    r = '0;
    e.lat = 1;
    case (op)
      AND_:  r = a & b;
      OR_:   r = a | b;
      ADD:   r = a + b;
      SUB:   r = a - b;
      SLT:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      NOR_:  r = ~(a | b);
      SLL:   r = b << s;
      SRL:   r = b >> s;
      SRA:   r = $signed(b) >>> s;
      MFHI:  r = m_hi;
      MFLO:  r = m_lo;
      MULTU: begin
        p = 64'(a) * 64'(b);
        m_hi = p[2*W-1:W];
        m_lo = p[W-1:0];
        r = m_lo;
        e.lat = W + 1;
      end
`ifdef SEQ_ALU_DIV_EN
      DIVU: begin
        if (b == 0) begin
          m_lo = '1;
          m_hi = a;
        end else begin
          m_lo = a / b;
          m_hi = a % b;
          e.lat = W + 1;
        end
        r = m_lo;
      end
`endif
      default: r = '0;
    endcase
    e.op = op;
    e.res = r;
    e.z = (r == 0);
    e.hi = m_hi;
    e.lo = m_lo;
    e.issue_cyc = cyc;
    exp_q.push_back(e);
  endtask

  // Drive one request at a negedge once the ALU is free; operands are scrambled afterwards
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] sh, input bit track);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: got busy=1 for %0d cycles expected release", n);
    end
    bus.ALU_control = op;
    bus.read_data_1 = a;
    bus.read_data_2 = b;
    bus.shamt = sh;
    bus.start = 1'b1;
    if (track) model(op, a, b, sh);
    @(negedge clk);
    bus.start = 1'b0;
    bus.read_data_1 = $urandom;
    bus.read_data_2 = $urandom;
    bus.shamt = 5'($urandom);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ALU_result"}, bus.ALU_result, '0);
    chk({tag, " zero"}, {31'b0, bus.zero}, '0);
    chk({tag, " busy"}, {31'b0, bus.busy}, '0);
    chk({tag, " done"}, {31'b0, bus.done}, '0);
    chk({tag, " hi"}, bus.hi, '0);
    chk({tag, " lo"}, bus.lo, '0);
  endtask

  initial begin
    logic [3:0] op;
    logic [W-1:0] a, b;
    int n;
    bus.start = 1'b0;
    bus.read_data_1 = '0;
    bus.read_data_2 = '0;
    bus.shamt = '0;
    bus.ALU_control = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;

    // Directed cases
    issue(ADD, 32'd13, 32'd5, 5'd0, 1);
    issue(SUB, 32'd29, 32'd23, 5'd0, 1);
    issue(SUB, 32'd77, 32'd77, 5'd0, 1);
    issue(SLT, 32'd8, 32'd2, 5'd0, 1);
    issue(SLT, 32'hFFFF_FFFF, 32'd2, 5'd0, 1);
    issue(SLL, 32'd0, 32'd16, 5'd2, 1);
    issue(SRA, 32'd0, 32'h8000_0000, 5'd4, 1);
    issue(SRL, 32'd0, 32'h8000_0000, 5'd31, 1);
    issue(NOR_, 32'h0F0F_0000, 32'h0000_00F0, 5'd0, 1);
    issue(MULTU, 32'hFFFF_FFFF, 32'd2, 5'd0, 1);
    issue(MFLO, 32'd0, 32'd0, 5'd0, 1);
    issue(MFHI, 32'd0, 32'd0, 5'd0, 1);
    issue(DIVU, 32'd100, 32'd7, 5'd0, 1);
    issue(MFHI, 32'd0, 32'd0, 5'd0, 1);
    issue(DIVU, 32'd5, 32'd0, 5'd0, 1);
    issue(MFHI, 32'd0, 32'd0, 5'd0, 1);
    issue(4'b0011, 32'd1, 32'd1, 5'd0, 1);
    issue(4'b0101, 32'd9, 32'd3, 5'd0, 1);

    // multu with operand churn and a dropped start while busy
    issue(MULTU, 32'd7, 32'd6, 5'd0, 1);
    for (int i = 0; i < 34; i++) begin
      bus.read_data_1 = $urandom;
      bus.read_data_2 = $urandom;
      bus.ALU_control = (i == 8) ? ADD : 4'($urandom);
      bus.start = (i == 8);
      @(negedge clk);
    end
    bus.start = 1'b0;
    issue(MFLO, 32'd0, 32'd0, 5'd0, 1);

    // Reset in the middle of a multu: no completion, everything cleared
    issue(MULTU, 32'd123, 32'd456, 5'd0, 0);
    repeat (13) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("midop_reset");
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    repeat (40) @(negedge clk);
    issue(MFHI, 32'd0, 32'd0, 5'd0, 1);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom);
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      issue(op, a, b, 5'($urandom), 1);
    end

    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("pending_responses", W'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
